// File: rtl/neuron_tac_array.sv
// Multi-input TAC neuron: accumulates signed weighted pulses over a frame, then ReLU, shift, bias, saturate.
// Optional macro NEURON_ACC_SAT_EN: clamp the accumulator on every update instead of wrapping.
module neuron_tac_array #(
   parameter int N_IN      = 4,
   parameter int W_WIDTH   = 8,
   parameter int ACC_WIDTH = 18,
   parameter int FRAME_LEN = 16,
   parameter int SHIFT     = 2,
   parameter int OUT_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [N_IN*W_WIDTH-1:0]   win,
   input  logic [N_IN-1:0]           sign_w,
   input  logic [OUT_WIDTH-1:0]      bias,
   input  logic [N_IN-1:0]           tac_in,
   input  logic [N_IN-1:0]           sign_x,
   output logic                      busy,
   output logic [OUT_WIDTH-1:0]      dout,
   output logic                      dout_valid,
   input  logic                      dout_ready
);

   localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam int SUM_W = W_WIDTH + $clog2(N_IN) + 2;
   localparam int Q_W   = ((ACC_WIDTH > OUT_WIDTH) ? ACC_WIDTH : OUT_WIDTH) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_POST  = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

   state_t                        state_q, state_d;
   logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]              cnt_q, cnt_d;
   logic [N_IN*W_WIDTH-1:0]       w_q, w_d;
   logic [N_IN-1:0]               sw_q, sw_d;
   logic [OUT_WIDTH-1:0]          bias_q, bias_d;
   logic [OUT_WIDTH-1:0]          dout_q, dout_d;
   logic                          valid_q, valid_d;

   logic signed [SUM_W-1:0]       cycle_sum;
   logic signed [ACC_WIDTH-1:0]   acc_step;
   logic [ACC_WIDTH-1:0]          relu;
   logic [Q_W-1:0]                q;
   logic [OUT_WIDTH-1:0]          post_dout;

   // Signed contribution of this cycle's pulses using the captured weights and signs.
   always_comb begin
      cycle_sum = '0;
      for (int unsigned i = 0; i < N_IN; i++) begin
         if (tac_in[i]) begin
            if (sign_x[i] ^ sw_q[i])
               cycle_sum = cycle_sum - $signed(SUM_W'(w_q[i*W_WIDTH +: W_WIDTH]));
            else
               cycle_sum = cycle_sum + $signed(SUM_W'(w_q[i*W_WIDTH +: W_WIDTH]));
         end
      end
   end

`ifdef NEURON_ACC_SAT_EN
   localparam int EXT_W = ((ACC_WIDTH > SUM_W) ? ACC_WIDTH : SUM_W) + 2;
   localparam logic signed [EXT_W-1:0] ACC_MAX =
      signed'({{(EXT_W-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}});
   localparam logic signed [EXT_W-1:0] ACC_MIN =
      signed'({{(EXT_W-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}});
   logic signed [EXT_W-1:0] acc_sum;

   always_comb begin
      acc_sum = EXT_W'(acc_q) + EXT_W'(cycle_sum);
      if (acc_sum > ACC_MAX)
         acc_step = ACC_MAX[ACC_WIDTH-1:0];
      else if (acc_sum < ACC_MIN)
         acc_step = ACC_MIN[ACC_WIDTH-1:0];
      else
         acc_step = acc_sum[ACC_WIDTH-1:0];
   end
`else
   always_comb begin
      acc_step = acc_q + ACC_WIDTH'(cycle_sum);
   end
`endif

   // Post-processing is sized to Q_W so shift+bias never wraps before saturation.
   always_comb begin
      relu      = acc_q[ACC_WIDTH-1] ? '0 : acc_q;
      q         = Q_W'(relu >> SHIFT) + Q_W'(bias_q);
      post_dout = (|q[Q_W-1:OUT_WIDTH]) ? '1 : q[OUT_WIDTH-1:0];
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      w_d     = w_q;
      sw_d    = sw_q;
      bias_d  = bias_q;
      dout_d  = dout_q;
      valid_d = valid_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               w_d     = win;
               sw_d    = sign_w;
               bias_d  = bias;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = S_ACCUM;
            end
         end
         S_ACCUM: begin
            acc_d = acc_step;
            if (cnt_q == CNT_LAST)
               state_d = S_POST;
            else
               cnt_d = cnt_q + CNT_W'(1);
         end
         S_POST: begin
            dout_d  = post_dout;
            valid_d = 1'b1;
            state_d = S_HOLD;
         end
         S_HOLD: begin
            if (dout_ready) begin
               valid_d = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         w_q     <= '0;
         sw_q    <= '0;
         bias_q  <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         w_q     <= w_d;
         sw_q    <= sw_d;
         bias_q  <= bias_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
      end
   end

   assign busy       = (state_q != S_IDLE);
   assign dout       = dout_q;
   assign dout_valid = valid_q;

endmodule
